salyut1_rstctrl: RTL

Reset request controller for the Salyut-1 SoC. It runs on the always-on board clock and collects reset requests from the reset button, the watchdog, software and the debugger. It prioritises them and produces stretched, registered `full_rst` / `cpu_rst` pulses that drive the reset sequencer and the CPU reset synchroniser. It also keeps a sticky reset-cause register for software.

---
 rtl/salyut1_rstctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/salyut1_rstctrl.sv
// Salyut-1 reset request controller: button debounce, request priority,
// stretched full/cpu reset pulses and a sticky reset-cause register.
module salyut1_rstctrl #(
  parameter int FULL_CYCLES     = 64,
  parameter int CPU_CYCLES      = 16,
  parameter int HOLDOFF_CYCLES  = 8,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       wdt_req,
  input  logic       sw_full_req,
  input  logic       sw_cpu_req,
  input  logic       dbg_cpu_hold,
  input  logic       cause_clr,
  output logic       full_rst,
  output logic       cpu_rst,
  output logic       busy,
  output logic [4:0] rst_cause
);

  localparam int MAX_FC = (FULL_CYCLES > CPU_CYCLES) ?
                          FULL_CYCLES : CPU_CYCLES;
  localparam int MAX_C  = (MAX_FC > HOLDOFF_CYCLES) ?
                          MAX_FC : HOLDOFF_CYCLES;
  localparam int CW     = $clog2(MAX_C);
  localparam int DW     = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CW-1:0] FULL_LD = CW'(FULL_CYCLES - 1);
  localparam logic [CW-1:0] CPU_LD  = CW'(CPU_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLDOFF_CYCLES - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_HIT = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FULL_ASSERT,
    CPU_ASSERT,
    HOLDOFF
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;
  logic            btn_s1;
  logic            btn_s2;
  logic [DW-1:0]   deb_cnt;
  logic            btn_req;
  logic [2:0]      pend_src;
  logic [2:0]      pend_src_n;
  logic            pend_cpu;
  logic            pend_cpu_n;
  logic            dbg_q;
  logic            take_full;
  logic            take_cpu;
  logic [2:0]      full_live;
  logic            full_any;
  logic            cpu_any;
  logic [4:0]      cause_set;
  logic [4:0]      cause_n;

  // Counter saturates, so a long press can only hit the fire value once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      deb_cnt <= '0;
      btn_req <= 1'b0;
    end else begin
      btn_s1  <= btn_raw;
      btn_s2  <= btn_s1;
      btn_req <= btn_s2 && (deb_cnt == DEB_HIT);
      if (!btn_s2) begin
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_MAX) begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  // Bit order matches rst_cause[3:1]: {sw_full, watchdog, button}.
  assign full_live = {sw_full_req, wdt_req, btn_req};
  assign full_any  = (|full_live) || (|pend_src);
  assign cpu_any   = sw_cpu_req || dbg_cpu_hold || pend_cpu;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    take_full = 1'b0;
    take_cpu  = 1'b0;
    unique case (state)
      IDLE: begin
        if (full_any) begin
          state_n   = FULL_ASSERT;
          cnt_n     = FULL_LD;
          take_full = 1'b1;
        end else if (cpu_any) begin
          state_n  = CPU_ASSERT;
          cnt_n    = CPU_LD;
          take_cpu = 1'b1;
        end
      end
      FULL_ASSERT: begin
        if (cnt == '0) begin
          state_n = HOLDOFF;
          cnt_n   = HOLD_LD;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      CPU_ASSERT: begin
        if (full_any) begin
          state_n   = FULL_ASSERT;
          cnt_n     = FULL_LD;
          take_full = 1'b1;
        end else if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else if (!dbg_cpu_hold && !dbg_q) begin
          // dbg_q keeps cpu_rst one cycle past the debugger release
          state_n = HOLDOFF;
          cnt_n   = HOLD_LD;
        end
      end
      HOLDOFF: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    pend_src_n = pend_src | full_live;
    pend_cpu_n = pend_cpu | sw_cpu_req;
    cause_set  = '0;
    if (take_full) begin
      pend_src_n     = '0;
      pend_cpu_n     = 1'b0;
      cause_set[3:1] = full_live | pend_src;
    end else if (take_cpu) begin
      pend_cpu_n   = 1'b0;
      cause_set[4] = 1'b1;
    end
    cause_n = (cause_clr ? 5'b0 : rst_cause) | cause_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FULL_ASSERT;
      cnt       <= FULL_LD;
      full_rst  <= 1'b1;
      cpu_rst   <= 1'b1;
      pend_src  <= '0;
      pend_cpu  <= 1'b0;
      dbg_q     <= 1'b0;
      rst_cause <= 5'b00001;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      full_rst  <= (state_n == FULL_ASSERT);
      cpu_rst   <= (state_n == FULL_ASSERT) ||
                   (state_n == CPU_ASSERT);
      pend_src  <= pend_src_n;
      pend_cpu  <= pend_cpu_n;
      dbg_q     <= dbg_cpu_hold;
      rst_cause <= cause_n;
    end
  end

  assign busy = (state != IDLE);

endmodule
